// File: rtl/dmem_arbiter.sv
// Two-port (CPU/DMA) arbiter in front of a byte-lane data memory with synchronous read.
// The CPU wins conflicts, and the DMA port is forced through after STARVE_MAX consecutive losses.
module dmem_arbiter #(
   parameter int STARVE_MAX = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        c_req,
   input  logic [3:0]  c_wren,
   input  logic [7:0]  c_addr,
   input  logic [31:0] c_wdata,
   output logic        c_gnt,
   output logic        c_rvalid,
   output logic [31:0] c_rdata,
   input  logic        d_req,
   input  logic [3:0]  d_wren,
   input  logic [7:0]  d_addr,
   input  logic [31:0] d_wdata,
   output logic        d_gnt,
   output logic        d_rvalid,
   output logic [31:0] d_rdata,
   output logic [7:0]  mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wren,
   input  logic [31:0] mem_rdata
);
   localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);
   localparam logic [3:0] WREN_READ  = 4'b1111;

   logic [2:0]  starve_q;
   logic [2:0]  starve_d;
   logic        rd_pend_q;
   logic        rd_pend_d;
   logic        rd_dma_q;
   logic        rd_dma_d;
   logic [31:0] c_rdata_q;
   logic [31:0] d_rdata_q;
   logic        conflict_s;

   assign conflict_s = c_req & d_req;

   // Grant selection; reset masks both grants immediately.
   always_comb begin
      c_gnt = 1'b0;
      d_gnt = 1'b0;
      if (!rst_n) begin
         c_gnt = 1'b0;
         d_gnt = 1'b0;
      end else if (conflict_s) begin
         if (starve_q == STARVE_LIM) begin
            d_gnt = 1'b1;
         end else begin
            c_gnt = 1'b1;
         end
      end else begin
         c_gnt = c_req;
         d_gnt = d_req;
      end
   end

   // Memory port follows the granted requester in the grant cycle itself.
   always_comb begin
      mem_addr  = 8'h00;
      mem_wdata = 32'h0000_0000;
      mem_wren  = WREN_READ;
      if (c_gnt) begin
         mem_addr  = c_addr;
         mem_wdata = c_wdata;
         mem_wren  = c_wren;
      end else if (d_gnt) begin
         mem_addr  = d_addr;
         mem_wdata = d_wdata;
         mem_wren  = d_wren;
      end else begin
         mem_addr  = 8'h00;
         mem_wdata = 32'h0000_0000;
         mem_wren  = WREN_READ;
      end
   end

   // Starvation counter and pending-read bookkeeping.
   always_comb begin
      starve_d = starve_q;
      if (!d_req || d_gnt) begin
         starve_d = 3'd0;
      end else if (c_gnt && (starve_q < STARVE_LIM)) begin
         starve_d = starve_q + 3'd1;
      end else begin
         starve_d = starve_q;
      end
      rd_pend_d = (c_gnt && (c_wren == WREN_READ)) || (d_gnt && (d_wren == WREN_READ));
      rd_dma_d  = d_gnt;
   end

   // State registers; returned read data is captured so rdata holds between reads.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         starve_q  <= 3'd0;
         rd_pend_q <= 1'b0;
         rd_dma_q  <= 1'b0;
         c_rdata_q <= 32'h0000_0000;
         d_rdata_q <= 32'h0000_0000;
      end else begin
         starve_q  <= starve_d;
         rd_pend_q <= rd_pend_d;
         rd_dma_q  <= rd_dma_d;
         if (c_rvalid) begin
            c_rdata_q <= mem_rdata;
         end
         if (d_rvalid) begin
            d_rdata_q <= mem_rdata;
         end
      end
   end

   // Read data arrives from memory one cycle after the grant and is forwarded directly.
   assign c_rvalid = rd_pend_q & ~rd_dma_q;
   assign d_rvalid = rd_pend_q & rd_dma_q;
   assign c_rdata  = c_rvalid ? mem_rdata : c_rdata_q;
   assign d_rdata  = d_rvalid ? mem_rdata : d_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: a reference model predicts grants, memory traffic
// and read returns; a negedge monitor compares what the DUT presents against the queues.
module tb_dmem_arbiter;
   localparam int STARVE_MAX = 4;

   typedef struct { logic req; logic [3:0] wren; logic [7:0] addr; logic [31:0] wdata; } port_t;
   typedef struct { logic cg; logic dg; logic [7:0] addr; logic [31:0] wdata; logic [3:0] wren; } gexp_t;
   typedef struct { logic is_d; logic [31:0] data; int due; } rexp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        c_req, d_req;
   logic [3:0]  c_wren, d_wren;
   logic [7:0]  c_addr, d_addr;
   logic [31:0] c_wdata, d_wdata;
   logic        c_gnt, d_gnt, c_rvalid, d_rvalid;
   logic [31:0] c_rdata, d_rdata;
   logic [7:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wren;
   logic [31:0] mem_rdata;

   logic [7:0]  mem [256][4];
   logic [7:0]  ref_mem [256][4];
   bit          mem_loaded = 1'b0;
   int          cyc = 0;
   int          streak = 0;
   int          n_cmp = 0;
   int          n_fail = 0;
   logic [31:0] last_c = 32'h0;
   logic [31:0] last_d = 32'h0;
   gexp_t       gq[$];
   rexp_t       rq[$];

   dmem_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
      .clk(clk), .rst_n(rst_n),
      .c_req(c_req), .c_wren(c_wren), .c_addr(c_addr), .c_wdata(c_wdata),
      .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
      .d_req(d_req), .d_wren(d_wren), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wren(mem_wren), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [7:0] preload(input int a, input int l);
      logic [31:0] w;
      w = 32'hDEADBEEF;
      if (a == 16) return w[8*l +: 8];
      return 8'((a * 13) + (l * 71) + 5);
   endfunction

   // Byte-lane memory with synchronous read, sitting behind the arbiter.
   always @(posedge clk) begin
      if (!mem_loaded) begin
         for (int a = 0; a < 256; a++)
            for (int l = 0; l < 4; l++) mem[a][l] = preload(a, l);
         mem_loaded = 1'b1;
      end
      mem_rdata <= {mem[mem_addr][3], mem[mem_addr][2], mem[mem_addr][1], mem[mem_addr][0]};
      for (int l = 0; l < 4; l++)
         if (!mem_wren[l]) mem[mem_addr][l] = mem_wdata[8*l +: 8];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %h required %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic port_t mk(input logic req, input logic [3:0] wren, input logic [7:0] addr,
                                input logic [31:0] wdata);
      port_t p;
      p.req = req; p.wren = wren; p.addr = addr; p.wdata = wdata;
      return p;
   endfunction

   function automatic port_t rnd_req();
      logic [3:0] w;
      w = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom_range(0, 15));
      return mk(1'b1, w, 8'($urandom_range(0, 15)), $urandom);
   endfunction

   function automatic logic [31:0] ref_word(input logic [7:0] a);
      return {ref_mem[a][3], ref_mem[a][2], ref_mem[a][1], ref_mem[a][0]};
   endfunction

   task automatic drive(input port_t c, input port_t d);
      c_req = c.req; c_wren = c.wren; c_addr = c.addr; c_wdata = c.wdata;
      d_req = d.req; d_wren = d.wren; d_addr = d.addr; d_wdata = d.wdata;
   endtask

   task automatic reset_checks(input string t);
      chk({t, "_c_gnt"},    32'(c_gnt),    32'd0);
      chk({t, "_d_gnt"},    32'(d_gnt),    32'd0);
      chk({t, "_c_rvalid"}, 32'(c_rvalid), 32'd0);
      chk({t, "_d_rvalid"}, 32'(d_rvalid), 32'd0);
      chk({t, "_c_rdata"},  c_rdata,       32'd0);
      chk({t, "_d_rdata"},  d_rdata,       32'd0);
      chk({t, "_mem_wren"}, 32'(mem_wren), 32'hF);
      chk({t, "_mem_addr"}, 32'(mem_addr), 32'd0);
      chk({t, "_mem_wdata"}, mem_wdata,    32'd0);
   endtask

   // One bus cycle: drive requests, predict the outcome from the arbitration rules.
   task automatic step(input port_t c, input port_t d, output logic cg, output logic dg);
      gexp_t g;
      rexp_t r;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      drive(c, d);
      if (c.req && d.req) begin
         dg = (streak == STARVE_MAX);
         cg = !dg;
      end else begin
         cg = c.req;
         dg = d.req;
      end
      g.cg = cg; g.dg = dg; g.addr = 8'h00; g.wdata = 32'h0; g.wren = 4'hF;
      if (cg) begin
         g.addr = c.addr; g.wdata = c.wdata; g.wren = c.wren;
      end else if (dg) begin
         g.addr = d.addr; g.wdata = d.wdata; g.wren = d.wren;
      end
      gq.push_back(g);
      if ((cg || dg) && (g.wren == 4'hF)) begin
         r.is_d = dg; r.data = ref_word(g.addr); r.due = cyc + 1;
         rq.push_back(r);
      end else if (cg || dg) begin
         for (int l = 0; l < 4; l++)
            if (!g.wren[l]) ref_mem[g.addr][l] = g.wdata[8*l +: 8];
      end
      if (!d.req || dg) streak = 0;
      else streak = streak + 1;
   endtask

   // Monitor: compare grants/memory drive every cycle, read returns whenever they appear.
   initial begin : monitor
      gexp_t g;
      rexp_t r;
      forever begin
         @(negedge clk);
         if (gq.size() > 0) begin
            g = gq.pop_front();
            chk("c_gnt", 32'(c_gnt), 32'(g.cg));
            chk("d_gnt", 32'(d_gnt), 32'(g.dg));
            chk("mem_addr", 32'(mem_addr), 32'(g.addr));
            chk("mem_wdata", mem_wdata, g.wdata);
            chk("mem_wren", 32'(mem_wren), 32'(g.wren));
         end
         if (c_rvalid || d_rvalid) begin
            if (rq.size() == 0) begin
               chk("unexpected_rvalid", 32'({c_rvalid, d_rvalid}), 32'd0);
            end else begin
               r = rq.pop_front();
               chk("rvalid_due", 32'(cyc), 32'(r.due));
               chk("rvalid_port", 32'({c_rvalid, d_rvalid}), r.is_d ? 32'd1 : 32'd2);
               if (r.is_d) last_d = r.data;
               else last_c = r.data;
            end
         end else if (rq.size() > 0 && rq[0].due <= cyc) begin
            r = rq.pop_front();
            chk("missing_rvalid", 32'({c_rvalid, d_rvalid}), r.is_d ? 32'd1 : 32'd2);
         end
         chk("c_rdata", c_rdata, last_c);
         chk("d_rdata", d_rdata, last_d);
      end
   end

   initial begin : stim
      port_t cp, dp, idle;
      logic  cg, dg;
      for (int a = 0; a < 256; a++)
         for (int l = 0; l < 4; l++) ref_mem[a][l] = preload(a, l);
      idle = mk(1'b0, 4'hF, 8'h00, 32'h0);
      drive(idle, idle);
      c_req = 1'b1;
      #1 rst_n = 1'b0;
      #1 reset_checks("por");
      c_req = 1'b0;
      repeat (2) @(posedge clk);

      // CPU-only read of the preloaded word, then DMA partial write and read-back
      step(mk(1'b1, 4'hF, 8'h10, 32'h0), idle, cg, dg);
      step(idle, idle, cg, dg);
      step(idle, mk(1'b1, 4'b1100, 8'h20, 32'h11223344), cg, dg);
      step(mk(1'b1, 4'hF, 8'h20, 32'h0), idle, cg, dg);
      // read, write, read of one address on consecutive cycles
      step(mk(1'b1, 4'hF, 8'h05, 32'h0), idle, cg, dg);
      step(mk(1'b1, 4'b0000, 8'h05, 32'hCAFEF00D), idle, cg, dg);
      step(mk(1'b1, 4'hF, 8'h05, 32'h0), idle, cg, dg);
      step(idle, idle, cg, dg);

      // continuous contention: C,C,C,C,D,C,C,C,C,D
      cp = rnd_req(); dp = rnd_req();
      for (int i = 0; i < 10; i++) begin
         step(cp, dp, cg, dg);
         if (cg) cp = rnd_req();
         if (dg) dp = rnd_req();
      end
      step(idle, idle, cg, dg);

      // DMA raises, withdraws before grant, then raises again
      cp = rnd_req(); dp = rnd_req();
      for (int i = 0; i < 12; i++) begin
         dp.req = (i != 2);
         step(cp, dp, cg, dg);
         if (cg) cp = rnd_req();
         if (dg) dp = rnd_req();
      end
      step(idle, idle, cg, dg);

      // reset asserted in a read-grant cycle with the starvation count non-zero
      cp = rnd_req(); dp = rnd_req();
      for (int i = 0; i < 2; i++) begin
         step(cp, dp, cg, dg);
         if (cg) cp = rnd_req();
         if (dg) dp = rnd_req();
      end
      @(posedge clk);
      #1;
      drive(mk(1'b1, 4'hF, 8'h07, 32'h0), dp);
      #1 chk("rst_cycle_c_gnt", 32'(c_gnt), 32'd1);
      rst_n = 1'b0;
      gq.delete(); rq.delete();
      streak = 0; last_c = 32'h0; last_d = 32'h0;
      #1 reset_checks("mid");
      drive(idle, idle);
      cp = rnd_req(); dp = rnd_req();
      for (int i = 0; i < 8; i++) begin
         step(cp, dp, cg, dg);
         if (cg) cp = rnd_req();
         if (dg) dp = rnd_req();
      end

      // randomized traffic with occasional withdrawals
      cp = idle; dp = idle;
      for (int i = 0; i < 400; i++) begin
         if (!cp.req && $urandom_range(0, 3) != 0) cp = rnd_req();
         else if (cp.req && $urandom_range(0, 15) == 0) cp.req = 1'b0;
         if (!dp.req && $urandom_range(0, 3) != 0) dp = rnd_req();
         else if (dp.req && $urandom_range(0, 15) == 0) dp.req = 1'b0;
         step(cp, dp, cg, dg);
         if (cg) cp.req = 1'b0;
         if (dg) dp.req = 1'b0;
      end

      repeat (3) step(idle, idle, cg, dg);
      @(negedge clk);
      #1 chk("rsp_drained", 32'(rq.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Parameters
REQ-001 SHALL have parameter STARVE_MAX, default 4, meaning consecutive conflict cycles the CPU may win before the DMA port is forced to win.

Interface
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port c_req  input  1  CPU port access request.
REQ-005 SHALL have port c_wren  input  4  CPU byte-lane write enables, active-low; 4'b1111 means read.
REQ-006 SHALL have port c_addr  input  8  CPU word address.
REQ-007 SHALL have port c_wdata  input  32  CPU write data, byte lane i = bits [8i+7:8i].
REQ-008 SHALL have port c_gnt  output  1  CPU request accepted this cycle.
REQ-009 SHALL have port c_rvalid  output  1  CPU read data valid.
REQ-010 SHALL have port c_rdata  output  32  CPU read data.
REQ-011 SHALL have ports d_req, d_wren, d_addr, d_wdata, d_gnt, d_rvalid, d_rdata with the same directions, widths and meanings for the DMA port.
REQ-012 SHALL have port mem_addr  output  8  word address to the four byte-lane memories.
REQ-013 SHALL have port mem_wdata  output  32  write data to memory lanes.
REQ-014 SHALL have port mem_wren  output  4  per-lane write enables, active-low.
REQ-015 SHALL have port mem_rdata  input  32  memory read data, valid one cycle after address (synchronous read).

Function
REQ-016 SHALL grant at most one port per cycle; c_gnt and d_gnt are combinational from current requests and registered arbitration state, never both 1.
REQ-017 SHALL drive mem_addr/mem_wdata/mem_wren from the granted port in the grant cycle; with no grant, mem_wren = 4'b1111, mem_addr and mem_wdata = 0.
REQ-018 SHALL, with only one request active, grant that port.
REQ-019 SHALL, on conflict (both req), grant CPU unless starve_cnt == STARVE_MAX, in which case grant DMA.
REQ-020 SHALL keep a 3-bit starve_cnt: +1 on each conflict cycle won by CPU; cleared to 0 when DMA is granted or d_req = 0; saturates at STARVE_MAX.
REQ-021 SHALL require a requester to hold req, wren, addr, wdata stable until gnt; a request withdrawn before gnt is dropped without side effect.
REQ-022 SHALL, for a granted read (wren = 4'b1111), register the port id and assert that port's rvalid exactly one cycle later for one cycle, with rdata = mem_rdata.
REQ-023 SHALL, for a granted write (any wren bit 0), assert no rvalid; lanes with wren bit 1 are unchanged in memory.
REQ-024 SHALL hold c_rdata/d_rdata at last delivered value when rvalid = 0.
REQ-025 SHALL allow back-to-back grants every cycle, including read then write to the same address; the read returns pre-write data.
REQ-026 SHALL add exactly one cycle of read latency and zero cycles of grant latency.

Reset
REQ-027 SHALL on rst_n = 0 immediately force c_gnt, d_gnt, c_rvalid, d_rvalid = 0, c_rdata, d_rdata = 0, mem_wren = 4'b1111, mem_addr, mem_wdata = 0, starve_cnt = 0, pending-read state cleared.
REQ-028 SHALL drop any read granted in the cycle reset asserts; no rvalid after release for it.
REQ-029 SHALL accept requests in the first rising edge after rst_n deasserts.

Verification
REQ-030 SHALL cover: CPU-only read addr 8'h10, mem holds 32'hDEADBEEF -> c_gnt same cycle, c_rvalid next cycle with c_rdata 32'hDEADBEEF, d_* idle.
REQ-031 SHALL cover: DMA write addr 8'h20, d_wren 4'b1100, d_wdata 32'h11223344 -> mem_wren 4'b1100, only lanes 0-1 written (byte 8'h44, 8'h33), no d_rvalid.
REQ-032 SHALL cover: both ports request continuously, STARVE_MAX = 4 -> grant sequence C,C,C,C,D,C,C,C,C,D.
REQ-033 SHALL cover: read addr 8'h05 then write addr 8'h05 on consecutive cycles -> read returns old data, subsequent read returns new data.
REQ-034 SHALL cover: rst_n pulled low during a read grant cycle -> all outputs at reset values asynchronously, no rvalid after release, starve_cnt 0.
REQ-035 SHALL cover: DMA raises then drops d_req before grant during CPU traffic -> no DMA grant, starve_cnt returns to 0.
